alu_share_sched: RTL and testbench

//  Round-robin scheduler sharing one combinational 8-bit ALU (a, b, sel[2:0] -> out) among NREQ requesters.

---
 rtl/alu_share_sched_pkg.sv | 17 +
 rtl/alu_share_sched_rr_arbiter.sv | 39 +++
 rtl/alu_share_sched.sv | 156 +++++++++++++++
 tb/tb_alu_share_sched.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_share_sched_pkg.sv
// Shared types and constants for the ALU sharing scheduler.
package alu_sched_pkg;

  // Scheduler FSM encoding; code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // ALU opcode width.
  localparam int OPW  = 3;

  // Completed-response counter width.
  localparam int CNTW = 16;

endpackage

// File: rtl/alu_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester index at or above ptr
// wins; if there is none, the search wraps to the lowest index overall.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  logic          hit_hi;
  logic          hit_any;
  logic [PW-1:0] idx_hi;
  logic [PW-1:0] idx_any;

  // Scan downward so the last hit is the lowest index: one pass over the
  // upper window [ptr, NREQ-1] and one over all requesters for the wrap case.
  always_comb begin
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    idx_hi  = '0;
    idx_any = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_any = 1'b1;
        idx_any = PW'(i);
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = PW'(i);
        end
      end
    end
    gnt_idx = hit_hi ? idx_hi : idx_any;
    gnt     = hit_any ? (NREQ'(1) << gnt_idx) : '0;
  end

endmodule

// File: rtl/alu_share_sched.sv
// Round-robin scheduler that time-shares one external combinational ALU
// among NREQ requesters and returns each result with its requester index.
module alu_share_sched
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NREQ  = 4,
  parameter int IDW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*OPW-1:0]   req_sel,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [OPW-1:0]     alu_sel,
  input  logic [WIDTH-1:0]   alu_out,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               busy,
  output logic [CNTW-1:0]    op_cnt
);

  localparam int PW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  alu_a_q, alu_a_d;
  logic [WIDTH-1:0]  alu_b_q, alu_b_d;
  logic [OPW-1:0]    alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [CNTW-1:0]   op_cnt_q, op_cnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;

  logic [NREQ-1:0]   gnt;
  logic [PW-1:0]     gnt_idx;
  logic [PW-1:0]     last_idx;
  logic [WIDTH-1:0]  mux_a;
  logic [WIDTH-1:0]  mux_b;
  logic [OPW-1:0]    mux_sel;
  logic              accept;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grant is offered only in IDLE and is suppressed while reset is asserted,
  // so a requester never sees an accept that the FSM is about to discard.
  assign req_ready = (state_q == ST_IDLE && rst) ? gnt : '0;
  assign accept    = |req_ready;
  assign last_idx  = PW'(rsp_id_q);

  // Select the granted requester's operands (grant is one-hot or zero).
  always_comb begin
    mux_a   = '0;
    mux_b   = '0;
    mux_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mux_a   = req_a[i*WIDTH +: WIDTH];
        mux_b   = req_b[i*WIDTH +: WIDTH];
        mux_sel = req_sel[i*OPW +: OPW];
      end
    end
  end

  // FSM next-state and register updates: IDLE accepts, EXEC captures the
  // ALU result, RESP holds it until the consumer takes it.
  always_comb begin
    state_d     = state_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    op_cnt_d    = op_cnt_q;
    ptr_d       = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          alu_a_d   = mux_a;
          alu_b_d   = mux_b;
          alu_sel_d = mux_sel;
          rsp_id_d  = IDW'(gnt_idx);
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_data_d  = alu_out;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_cnt_d    = op_cnt_q + CNTW'(1);
          // Requester just served drops to lowest priority.
          ptr_d       = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + PW'(1);
          state_d     = ST_IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      op_cnt_q    <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      op_cnt_q    <= op_cnt_d;
      ptr_q       <= ptr_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign op_cnt    = op_cnt_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed scoreboard bench for alu_share_sched with an XOR ALU stub.
module tb_alu_share_sched;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [11:0] req_sel;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        busy;
  logic [15:0] op_cnt;

  typedef struct packed {
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  alu_share_sched #(.WIDTH(8), .NREQ(4), .IDW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sel   (req_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_sel   (alu_sel),
    .alu_out   (alu_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_cnt    (op_cnt)
  );

  assign alu_out = alu_a ^ alu_b;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
    req_a[i*8 +: 8]   = a;
    req_b[i*8 +: 8]   = b;
    req_sel[i*3 +: 3] = s;
  endtask

  task automatic push_exp(input logic [1:0] id, input logic [7:0] data);
    exp_t e;
    e.id   = id;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Returns at the negedge where req_ready is nonzero, or 0 after the budget.
  task automatic wait_grant(output logic [3:0] g);
    g = 4'b0000;
    for (int k = 0; k < 20 && g == 4'b0000; k++) begin
      @(negedge clk);
      g = req_ready;
    end
  endtask

  task automatic wait_idle(input string name);
    logic done;
    done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Monitor: compare every accepted response against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got id=%0d data=%0h, expected no response", rsp_id, rsp_data);
        end else begin
          e = sb_q.pop_front();
          check("rsp_data", 32'(rsp_data), 32'(e.data));
          check("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
    end
  end

  initial begin
    logic [3:0] g;

    // Reset with every requester asking.
    rst       = 1'b0;
    req_valid = 4'b1111;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_op_cnt", 32'(op_cnt), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_alu_a", 32'(alu_a), 32'd0);

    // Single op from requester 0.
    @(posedge clk); #1;
    rst       = 1'b1;
    req_valid = 4'b0001;
    set_req(0, 8'h12, 8'h34, 3'd5);
    rsp_ready = 1'b1;
    push_exp(2'd0, 8'h26);
    wait_grant(g);
    check("single_grant", 32'(g), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    @(negedge clk);
    check("single_alu_a", 32'(alu_a), 32'h12);
    check("single_alu_b", 32'(alu_b), 32'h34);
    check("single_alu_sel", 32'(alu_sel), 32'd5);
    check("single_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("single_rsp_valid", 32'(rsp_valid), 32'd1);
    wait_idle("single_idle");
    check("single_op_cnt", 32'(op_cnt), 32'd1);

    // Re-reset so the pointer starts at 0, then all four compete.
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    set_req(0, 8'h01, 8'h10, 3'd0);
    set_req(1, 8'h22, 8'h03, 3'd1);
    set_req(2, 8'h44, 8'h0F, 3'd2);
    set_req(3, 8'h80, 8'hFF, 3'd3);
    push_exp(2'd0, 8'h11);
    push_exp(2'd1, 8'h21);
    push_exp(2'd2, 8'h4B);
    push_exp(2'd3, 8'h7F);
    push_exp(2'd0, 8'h11);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    wait_grant(g);
    check("rr_grant0", 32'(g), 32'b0001);
    wait_grant(g);
    check("rr_grant1", 32'(g), 32'b0010);
    wait_grant(g);
    check("rr_grant2", 32'(g), 32'b0100);
    wait_grant(g);
    check("rr_grant3", 32'(g), 32'b1000);
    wait_grant(g);
    check("rr_grant4", 32'(g), 32'b0001);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle("rr_idle");
    check("rr_op_cnt", 32'(op_cnt), 32'd5);

    // Backpressure: response held for 10 cycles with others waiting.
    @(posedge clk); #1;
    set_req(2, 8'h5A, 8'h0F, 3'd3);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    push_exp(2'd2, 8'h55);
    wait_grant(g);
    check("bp_grant", 32'(g), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1011;
    for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rsp_data", 32'(rsp_data), 32'h55);
      check("bp_rsp_id", 32'(rsp_id), 32'd2);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    check("bp_op_cnt_hold", 32'(op_cnt), 32'd5);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    check("bp_op_cnt", 32'(op_cnt), 32'd6);
    check("bp_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    check("bp_op_cnt_once", 32'(op_cnt), 32'd6);

    // Pointer at 3: requester 3 first, then wrap to 0 favours requester 1.
    @(posedge clk); #1;
    set_req(3, 8'hF0, 8'h0F, 3'd7);
    set_req(1, 8'hAA, 8'h0A, 3'd2);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    push_exp(2'd3, 8'hFF);
    push_exp(2'd1, 8'hA0);
    wait_grant(g);
    check("wrap_grant_first", 32'(g), 32'b1000);
    @(negedge clk);
    check("wrap_alu_a", 32'(alu_a), 32'hF0);
    check("wrap_alu_sel", 32'(alu_sel), 32'd7);
    wait_grant(g);
    check("wrap_grant_second", 32'(g), 32'b0010);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    wait_idle("wrap_idle");
    check("wrap_op_cnt", 32'(op_cnt), 32'd8);

    // Reset during EXEC: the op must vanish without a response.
    @(posedge clk); #1;
    set_req(0, 8'h33, 8'h11, 3'd1);
    req_valid = 4'b0001;
    rsp_ready = 1'b1;
    wait_grant(g);
    check("midrst_grant", 32'(g), 32'b0001);
    @(posedge clk); #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(negedge clk);
    check("midrst_exec_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst_op_cnt", 32'(op_cnt), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
